// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - EX-stage request/result bundle between pipeline control and mult_div_unit
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALU_Control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, ALU_Control, A, B,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, ALU_Control, A, B,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed multiply/divide into HI/LO; divider built only when MDU_DIV_EN is defined
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [3:0] OP_MULT = 4'b0101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        WB   = 2'd2
`ifdef MDU_DIV_EN
        , DIV = 2'd3
`endif
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_a;
    logic               res_neg;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               accept_mult, last_iter;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_upper;
    logic [2*WIDTH-1:0] prod_signed;

`ifdef MDU_DIV_EN
    localparam logic [3:0] OP_DIV = 4'b1011;
    logic               accept_div, b_zero, op_div, dvd_neg, dbz_pend, dbz_q;
    logic [WIDTH-1:0]   mag_b, quo, rem, quo_signed, rem_signed;
    logic [WIDTH:0]     rem_shift, rem_diff;

    assign accept_div = (state == IDLE) && bus.start && (bus.ALU_Control == OP_DIV);
    assign b_zero     = (bus.B == {WIDTH{1'b0}});
    assign rem_shift  = {rem, quo[WIDTH-1]};
    assign rem_diff   = rem_shift - {1'b0, mag_b};
    assign quo_signed = res_neg ? -quo : quo;
    assign rem_signed = dvd_neg ? -rem : rem;
    assign bus.div_by_zero = dbz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif

    assign accept_mult = (state == IDLE) && bus.start && (bus.ALU_Control == OP_MULT);
    assign last_iter   = (cnt == CW'(WIDTH - 1));
    assign abs_a       = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign abs_b       = bus.B[WIDTH-1] ? -bus.B : bus.B;
    // Shift-add keeps the carry of the upper-half add as the new top bit.
    assign mul_upper   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    assign prod_signed = res_neg ? -acc : acc;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_mult) state_nxt = MULT;
`ifdef MDU_DIV_EN
                else if (accept_div) state_nxt = b_zero ? WB : DIV;
`endif
            end
            MULT: if (last_iter) state_nxt = WB;
`ifdef MDU_DIV_EN
            DIV:  if (last_iter) state_nxt = WB;
`endif
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            acc     <= '0;
            mag_a   <= '0;
            res_neg <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MDU_DIV_EN
            op_div   <= 1'b0;
            dvd_neg  <= 1'b0;
            dbz_pend <= 1'b0;
            dbz_q    <= 1'b0;
            mag_b    <= '0;
            quo      <= '0;
            rem      <= '0;
`endif
        end else begin
            busy_q <= (state_nxt != IDLE);
            done_q <= (state == WB);
`ifdef MDU_DIV_EN
            dbz_q  <= (state == WB) && op_div && dbz_pend;
`endif
            case (state)
                IDLE: begin
                    if (accept_mult) begin
                        acc     <= {{WIDTH{1'b0}}, abs_b};
                        mag_a   <= abs_a;
                        res_neg <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        cnt     <= '0;
`ifdef MDU_DIV_EN
                        op_div  <= 1'b0;
`endif
                    end
`ifdef MDU_DIV_EN
                    else if (accept_div) begin
                        mag_b    <= abs_b;
                        quo      <= abs_a;
                        rem      <= '0;
                        res_neg  <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        dvd_neg  <= bus.A[WIDTH-1];
                        dbz_pend <= b_zero;
                        op_div   <= 1'b1;
                        cnt      <= '0;
                    end
`endif
                end
                MULT: begin
                    acc <= {mul_upper, acc[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                end
`ifdef MDU_DIV_EN
                DIV: begin
                    // Restore by keeping the shifted remainder when the trial subtract borrows.
                    rem <= rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~rem_diff[WIDTH]};
                    cnt <= cnt + CW'(1);
                end
`endif
                WB: begin
`ifdef MDU_DIV_EN
                    if (op_div) begin
                        if (!dbz_pend) begin
                            hi_q <= rem_signed;
                            lo_q <= quo_signed;
                        end
                    end else begin
                        {hi_q, lo_q} <= prod_signed;
                    end
`else
                    {hi_q, lo_q} <= prod_signed;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
